// File: rtl/voice_cfg_loader_pkg.sv
// Shared command encodings, FSM state type and per-command byte counts for the voice loader.
package voice_cfg_pkg;

  localparam logic [1:0] CMD_WR_TW  = 2'b00;
  localparam logic [1:0] CMD_WR_SEL = 2'b01;
  localparam logic [1:0] CMD_WR_ALL = 2'b10;
  localparam logic [1:0] CMD_CLR    = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D0     = 3'd1,
    D1     = 3'd2,
    D2     = 3'd3,
    COMMIT = 3'd4
  } state_t;

  function automatic logic [1:0] bytes_for_cmd(input logic [1:0] cmd);
    case (cmd)
      CMD_WR_TW:  bytes_for_cmd = 2'd2;
      CMD_WR_SEL: bytes_for_cmd = 2'd1;
      CMD_WR_ALL: bytes_for_cmd = 2'd3;
      default:    bytes_for_cmd = 2'd0;
    endcase
  endfunction

  function automatic logic cmd_writes_tw(input logic [1:0] cmd);
    cmd_writes_tw = (cmd != CMD_WR_SEL);
  endfunction

  function automatic logic cmd_writes_sel(input logic [1:0] cmd);
    cmd_writes_sel = (cmd != CMD_WR_TW);
  endfunction

endpackage

// File: rtl/voice_cfg_loader_byte_gap_timer.sv
// Idle-cycle counter between frame bytes; tc is high while the count sits at MAX.
// Registered count, clear has priority over enable.
module byte_gap_timer #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(MAX));

endmodule

// File: rtl/voice_cfg_loader.sv
// Byte-serial command loader for DDS voice tuning words and waveform selects.
// Fields are shadowed during a frame and land in the voice registers atomically one cycle after the last byte.
module voice_cfg_loader
  import voice_cfg_pkg::*;
#(
  parameter int NVOICE  = 4,
  parameter int TW      = 16,
  parameter int SELW    = 3,
  parameter int GAP_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     err_clr,
  output logic [NVOICE*TW-1:0]     tw_flat,
  output logic [NVOICE*SELW-1:0]   sel_flat,
  output logic [NVOICE-1:0]        commit,
  output logic                     busy,
  output logic                     err
);

  state_t                  state_q, state_d;
  logic [1:0]              voice_q, voice_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [TW-1:0]           sh_tw_q, sh_tw_d;
  logic [SELW-1:0]         sh_sel_q, sh_sel_d;
  logic [NVOICE*TW-1:0]    tw_q, tw_d;
  logic [NVOICE*SELW-1:0]  sel_q, sel_d;
  logic [NVOICE-1:0]       commit_q, commit_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic                    xfer;
  logic                    err_set;
  logic                    in_data;
  logic [1:0]              idx;
  logic                    gap_tc;
  logic                    gap_clr;
  logic                    gap_en;

  assign xfer    = in_valid & ready_q;
  assign in_data = (state_q == D0) || (state_q == D1) || (state_q == D2);
  assign gap_clr = !in_data || xfer || gap_tc;
  assign gap_en  = in_data && !xfer;

  byte_gap_timer #(
    .W   (8),
    .MAX (GAP_MAX)
  ) u_gap_timer (
    .clk (clk),
    .rst (rst),
    .clr (gap_clr),
    .en  (gap_en),
    .tc  (gap_tc)
  );

  always_comb begin
    state_d  = state_q;
    voice_d  = voice_q;
    cmd_d    = cmd_q;
    sh_tw_d  = sh_tw_q;
    sh_sel_d = sh_sel_q;
    tw_d     = tw_q;
    sel_d    = sel_q;
    commit_d = '0;
    err_set  = 1'b0;
    idx      = (state_q == D0) ? 2'd0 : (state_q == D1) ? 2'd1 : 2'd2;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (in_byte[3:0] != 4'b0000) begin
            err_set = 1'b1;
          end else begin
            voice_d  = in_byte[7:6];
            cmd_d    = in_byte[5:4];
            sh_tw_d  = '0;
            sh_sel_d = '0;
            state_d  = (in_byte[5:4] == CMD_CLR) ? COMMIT : D0;
          end
        end
      end
      D0, D1, D2: begin
        if (xfer) begin
          // Tuning bytes arrive MSB first, so shifting each one in assembles the word.
          case (cmd_q)
            CMD_WR_SEL: sh_sel_d = in_byte[SELW-1:0];
            CMD_WR_ALL: begin
              if (idx == 2'd0) begin
                sh_sel_d = in_byte[SELW-1:0];
              end else begin
                sh_tw_d = {sh_tw_q[TW-9:0], in_byte};
              end
            end
            default:    sh_tw_d = {sh_tw_q[TW-9:0], in_byte};
          endcase
          if ((idx + 2'd1) == bytes_for_cmd(cmd_q)) begin
            state_d = COMMIT;
          end else begin
            state_d = (state_q == D0) ? D1 : D2;
          end
        end else if (gap_tc) begin
          state_d  = IDLE;
          err_set  = 1'b1;
          sh_tw_d  = '0;
          sh_sel_d = '0;
        end
      end
      COMMIT: begin
        if (cmd_writes_tw(cmd_q)) begin
          tw_d[voice_q*TW +: TW] = sh_tw_q;
        end
        if (cmd_writes_sel(cmd_q)) begin
          sel_d[voice_q*SELW +: SELW] = sh_sel_q;
        end
        commit_d[voice_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != COMMIT);
    // A new error in the same cycle as a clear request must survive.
    err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      voice_q  <= '0;
      cmd_q    <= '0;
      sh_tw_q  <= '0;
      sh_sel_q <= '0;
      tw_q     <= '0;
      sel_q    <= '0;
      commit_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      voice_q  <= voice_d;
      cmd_q    <= cmd_d;
      sh_tw_q  <= sh_tw_d;
      sh_sel_q <= sh_sel_d;
      tw_q     <= tw_d;
      sel_q    <= sel_d;
      commit_q <= commit_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign in_ready = ready_q;
  assign tw_flat  = tw_q;
  assign sel_flat = sel_q;
  assign commit   = commit_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_voice_cfg_loader.sv
// Directed bench for voice_cfg_loader: framing, commit timing, errors, timeout, reset and stalls.
module tb_voice_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        err_clr;
  logic [63:0] tw_flat;
  logic [11:0] sel_flat;
  logic [3:0]  commit;
  logic        busy;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  voice_cfg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .err_clr  (err_clr),
    .tw_flat  (tw_flat),
    .sel_flat (sel_flat),
    .commit   (commit),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required finish before 400us");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    int w;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_ready byte=%h in_ready=%b, required 1 within 20 cycles", b, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0; in_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (tw_flat !== 64'h0) begin n_fail++; $display("FAIL reset_tw got=%h exp=0", tw_flat); end
    n_chk++; if (sel_flat !== 12'h0) begin n_fail++; $display("FAIL reset_sel got=%h exp=0", sel_flat); end
    n_chk++; if ({commit, err, busy, in_ready} !== 7'b0) begin n_fail++;
      $display("FAIL reset_ctrl got commit=%b err=%b busy=%b rdy=%b exp all 0", commit, err, busy, in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got=%b exp=1", in_ready); end
  endtask

  task automatic test_wr_tw;
    send(8'h40); send(8'h12); send(8'h34);
    @(negedge clk);
    n_chk++; if ({in_ready, busy, commit} !== 6'b0_1_0000) begin n_fail++;
      $display("FAIL wr_tw_commit_state got rdy=%b busy=%b commit=%b exp rdy=0 busy=1 commit=0000", in_ready, busy, commit); end
    n_chk++; if (tw_flat !== 64'h0) begin n_fail++; $display("FAIL wr_tw_early got=%h exp=0", tw_flat); end
    @(negedge clk);
    n_chk++; if (tw_flat !== 64'h0000_0000_1234_0000) begin n_fail++;
      $display("FAIL wr_tw_value got=%h exp=0000000012340000", tw_flat); end
    n_chk++; if ({commit, in_ready, busy} !== 6'b0010_1_0) begin n_fail++;
      $display("FAIL wr_tw_pulse got commit=%b rdy=%b busy=%b exp 0010 1 0", commit, in_ready, busy); end
    @(negedge clk);
    n_chk++; if (commit !== 4'b0000) begin n_fail++; $display("FAIL wr_tw_pulse_end got=%b exp=0000", commit); end
  endtask

  task automatic test_wr_all_sel;
    send(8'hE0); send(8'h05); send(8'hAB); send(8'hCD);
    repeat (2) @(negedge clk);
    n_chk++; if (sel_flat !== 12'hA00 || tw_flat !== 64'hABCD_0000_1234_0000) begin n_fail++;
      $display("FAIL wr_all got sel=%h tw=%h exp sel=a00 tw=abcd000012340000", sel_flat, tw_flat); end
    n_chk++; if (commit !== 4'b1000) begin n_fail++; $display("FAIL wr_all_commit got=%b exp=1000", commit); end
    send(8'hD0); send(8'hFE);
    repeat (2) @(negedge clk);
    n_chk++; if (sel_flat !== 12'hC00 || tw_flat !== 64'hABCD_0000_1234_0000) begin n_fail++;
      $display("FAIL wr_sel got sel=%h tw=%h exp sel=c00 tw=abcd000012340000", sel_flat, tw_flat); end
  endtask

  task automatic test_bad_header;
    send(8'h41);
    @(negedge clk);
    n_chk++; if ({err, busy, in_ready, commit} !== 7'b1_0_1_0000) begin n_fail++;
      $display("FAIL bad_hdr got err=%b busy=%b rdy=%b commit=%b exp 1 0 1 0000", err, busy, in_ready, commit); end
    send(8'h00); send(8'h55); send(8'h66);
    repeat (2) @(negedge clk);
    n_chk++; if (tw_flat !== 64'hABCD_0000_1234_5566 || commit !== 4'b0001) begin n_fail++;
      $display("FAIL after_bad_hdr got tw=%h commit=%b exp abcd000012345566 0001", tw_flat, commit); end
    @(negedge clk);
    in_byte = 8'h02; in_valid = 1'b1; err_clr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got err=%b exp=1", err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr got err=%b exp=0", err); end
  endtask

  task automatic test_timeout;
    int w;
    send(8'h00); send(8'h11);
    repeat (200) @(negedge clk);
    n_chk++; if (busy !== 1'b1 || err !== 1'b0) begin n_fail++;
      $display("FAIL gap_early got busy=%b err=%b exp busy=1 err=0", busy, err); end
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_abort got busy=%b exp=0 within 300 idle cycles", busy); end
    n_chk++; if (err !== 1'b1 || tw_flat[15:0] !== 16'h5566 || commit !== 4'b0) begin n_fail++;
      $display("FAIL gap_effects got err=%b tw0=%h commit=%b exp 1 5566 0000", err, tw_flat[15:0], commit); end
    send(8'h00); send(8'h77); send(8'h88);
    repeat (2) @(negedge clk);
    n_chk++; if (tw_flat[15:0] !== 16'h7788 || commit !== 4'b0001) begin n_fail++;
      $display("FAIL after_gap got tw0=%h commit=%b exp 7788 0001", tw_flat[15:0], commit); end
  endtask

  task automatic test_mid_reset;
    send(8'h80); send(8'h12);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (tw_flat !== 64'h0 || sel_flat !== 12'h0) begin n_fail++;
      $display("FAIL mid_rst_regs got tw=%h sel=%h exp 0 0", tw_flat, sel_flat); end
    n_chk++; if ({commit, err, busy, in_ready} !== 7'b0) begin n_fail++;
      $display("FAIL mid_rst_ctrl got commit=%b err=%b busy=%b rdy=%b exp all 0", commit, err, busy, in_ready); end
    send(8'h34);
    @(negedge clk);
    n_chk++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst_hdr got err=%b busy=%b exp err=1 busy=0", err, busy); end
    @(negedge clk);
    n_chk++; if (commit !== 4'b0 || tw_flat !== 64'h0) begin n_fail++;
      $display("FAIL mid_rst_nocommit got commit=%b tw=%h exp 0000 0", commit, tw_flat); end
  endtask

  task automatic test_clr_voice;
    send(8'hE0); send(8'h03); send(8'h12); send(8'h34);
    send(8'h80); send(8'hBE); send(8'hEF);
    repeat (2) @(negedge clk);
    n_chk++; if (tw_flat !== 64'h1234_BEEF_0000_0000 || sel_flat !== 12'h600) begin n_fail++;
      $display("FAIL clr_preload got tw=%h sel=%h exp 1234beef00000000 600", tw_flat, sel_flat); end
    send(8'hF0);
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0 || commit !== 4'b0) begin n_fail++;
      $display("FAIL clr_commit_cycle got rdy=%b commit=%b exp 0 0000", in_ready, commit); end
    @(negedge clk);
    n_chk++; if (tw_flat !== 64'h0000_BEEF_0000_0000 || sel_flat !== 12'h000 || commit !== 4'b1000) begin n_fail++;
      $display("FAIL clr_voice got tw=%h sel=%h commit=%b exp 0000beef00000000 000 1000", tw_flat, sel_flat, commit); end
  endtask

  task automatic test_back_to_back_stalls;
    logic [7:0] seq [$];
    seq = '{8'h40, 8'h12, 8'h34, 8'hE0, 8'h05, 8'hAB, 8'hCD, 8'hD0, 8'hFE,
            8'h10, 8'h07, 8'h90, 8'h0A};
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_byte = 8'($urandom);
      end
      send(seq[i]);
    end
    repeat (3) @(negedge clk);
    n_chk++; if (tw_flat !== 64'hABCD_0000_1234_0000) begin n_fail++;
      $display("FAIL stall_tw got=%h exp=abcd000012340000", tw_flat); end
    n_chk++; if (sel_flat !== 12'hC87 || err !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL stall_sel got sel=%h err=%b busy=%b exp c87 0 0", sel_flat, err, busy); end
  endtask

  initial begin
    test_reset();
    test_wr_tw();
    test_wr_all_sel();
    test_bad_header();
    test_timeout();
    test_mid_reset();
    test_clr_voice();
    test_back_to_back_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
